// File: rtl/cdc_pkg.sv
// Shared types and helpers for the req/ack crossing controller.
// Holds the handshake FSM encoding and a width helper.
package cdc_pkg;

    typedef enum logic [1:0] {
        IDLE,
        REQ_HI,
        REQ_LO,
        RECOVER
    } hs_state_t;

    // Index width that never collapses to zero bits
    function automatic int clog2_min1(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: search starts one past the last winner.
// Pointer advances only when the grant is actually taken.
module rr_arbiter
    import cdc_pkg::*;
#(
    parameter int N = 4
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic [N-1:0]             req_i,
    input  logic                     adv_i,
    output logic [N-1:0]             gnt_o,
    output logic [clog2_min1(N)-1:0] idx_o
);

    localparam int W = clog2_min1(N);

    logic [W-1:0] ptr_q;
    logic [W-1:0] ptr_d;
    logic [W-1:0] jw;
    logic         found;
    int           j;

    always_comb begin
        gnt_o = '0;
        idx_o = '0;
        found = 1'b0;
        j     = 0;
        jw    = '0;
        for (int k = 0; k < N; k++) begin
            j = int'(ptr_q) + k;
            if (j >= N) j = j - N;
            jw = W'(j);
            if (!found && req_i[jw]) begin
                found     = 1'b1;
                gnt_o[jw] = 1'b1;
                idx_o     = jw;
            end
        end
        ptr_d = ptr_q;
        if (adv_i && found) begin
            ptr_d = (idx_o == W'(N - 1)) ? '0 : idx_o + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) ptr_q <= '0;
        else       ptr_q <= ptr_d;
    end

endmodule

// File: rtl/cdc_hs_arbiter.sv
// Source-side four-phase req/ack controller sharing one crossing
// between several requesters, with per-phase ack timeout.
module cdc_hs_arbiter
    import cdc_pkg::*;
#(
    parameter int NUM_REQ     = 4,
    parameter int DATA_W      = 8,
    parameter int ACK_TIMEOUT = 255
) (
    input  logic                           CLK_I,
    input  logic                           RST_I,
    input  logic [NUM_REQ-1:0]             REQ_VALID_I,
    input  logic [NUM_REQ*DATA_W-1:0]      REQ_DATA_I,
    output logic [NUM_REQ-1:0]             REQ_READY_O,
    output logic                           XFER_REQ_O,
    output logic [DATA_W-1:0]              XFER_DATA_O,
    output logic [clog2_min1(NUM_REQ)-1:0] XFER_ID_O,
    input  logic                           XFER_ACK_I,
    output logic                           BUSY_O,
    output logic                           TIMEOUT_O,
    input  logic                           CLR_ERR_I
);

    localparam int IDW = clog2_min1(NUM_REQ);
    localparam int CW  = clog2_min1(ACK_TIMEOUT + 1);

    typedef logic [CW-1:0] cnt_t;
    localparam cnt_t CMAX = cnt_t'(ACK_TIMEOUT);

    hs_state_t         state_q, state_d;
    cnt_t              cnt_q, cnt_d, cnt_inc;
    logic              xreq_q, xreq_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic [IDW-1:0]    id_q, id_d;
    logic              to_q, to_d;
    logic              to_set, to_hit;
    logic              grant;
    logic [NUM_REQ-1:0] gnt;
    logic [IDW-1:0]    gidx;
    logic [DATA_W-1:0] lane [NUM_REQ];

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_lane
        assign lane[g] = REQ_DATA_I[g*DATA_W +: DATA_W];
    end

    // A stale ack from the previous handshake blocks any new grant
    assign grant = (state_q == IDLE) && !XFER_ACK_I
                 && (|REQ_VALID_I) && !RST_I;

    rr_arbiter #(
        .N(NUM_REQ)
    ) u_rr (
        .clk_i (CLK_I),
        .rst_i (RST_I),
        .req_i (REQ_VALID_I),
        .adv_i (grant),
        .gnt_o (gnt),
        .idx_o (gidx)
    );

    assign cnt_inc = (cnt_q == CMAX) ? CMAX : cnt_q + 1'b1;
    assign to_hit  = (ACK_TIMEOUT != 0) && (cnt_inc == CMAX);

    always_ff @(posedge CLK_I) begin
        if (RST_I) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            xreq_q  <= 1'b0;
            data_q  <= '0;
            id_q    <= '0;
            to_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            xreq_q  <= xreq_d;
            data_q  <= data_d;
            id_q    <= id_d;
            to_q    <= to_d;
        end
    end

    always_comb begin
        state_d = state_q;
        to_set  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (grant) state_d = REQ_HI;
            end
            REQ_HI: begin
                if (XFER_ACK_I) begin
                    state_d = REQ_LO;
                end else if (to_hit) begin
                    state_d = RECOVER;
                    to_set  = 1'b1;
                end
            end
            REQ_LO: begin
                if (!XFER_ACK_I) begin
                    state_d = IDLE;
                end else if (to_hit) begin
                    state_d = RECOVER;
                    to_set  = 1'b1;
                end
            end
            RECOVER: begin
                if (!XFER_ACK_I) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        cnt_d = '0;
        if (state_d == state_q
            && (state_q == REQ_HI || state_q == REQ_LO)) begin
            cnt_d = cnt_inc;
        end
        xreq_d      = (state_d == REQ_HI);
        data_d      = grant ? lane[gidx] : data_q;
        id_d        = grant ? gidx : id_q;
        to_d        = to_set ? 1'b1 : (CLR_ERR_I ? 1'b0 : to_q);
        REQ_READY_O = grant ? gnt : '0;
        BUSY_O      = (state_q != IDLE);
    end

    assign XFER_REQ_O  = xreq_q;
    assign XFER_DATA_O = data_q;
    assign XFER_ID_O   = id_q;
    assign TIMEOUT_O   = to_q;

endmodule

// File: tb/tb_cdc_hs_arbiter.sv
// Directed bench for cdc_hs_arbiter, plus a two-clock crossing
// scenario with a slower destination and an ordered scoreboard.
module tb_cdc_hs_arbiter;

    logic        clk = 1'b0;
    logic        clk_d = 1'b0;
    logic        rst = 1'b1;

    logic [3:0]  valid = '0;
    logic [31:0] data = '0;
    logic [3:0]  ready;
    logic        xreq;
    logic [7:0]  xdata;
    logic [1:0]  xid;
    logic        ack = 1'b0;
    logic        busy;
    logic        tout;
    logic        clr = 1'b0;

    logic [3:0]  v6 = '0;
    logic [31:0] d6 = '0;
    logic [3:0]  r6;
    logic        xreq6;
    logic [7:0]  xdata6;
    logic [1:0]  xid6;
    logic        ack6;
    logic        busy6;
    logic        tout6;
    logic        clr6 = 1'b0;

    logic        rs1, rs2, ackd, as1, as2;
    logic [9:0]  rxq[$];
    logic [9:0]  expq[$];

    int n_chk = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    initial begin
        #3;
        forever #15 clk_d = ~clk_d;
    end

    cdc_hs_arbiter #(
        .NUM_REQ(4), .DATA_W(8), .ACK_TIMEOUT(8)
    ) dut (
        .CLK_I(clk), .RST_I(rst),
        .REQ_VALID_I(valid), .REQ_DATA_I(data),
        .REQ_READY_O(ready), .XFER_REQ_O(xreq),
        .XFER_DATA_O(xdata), .XFER_ID_O(xid),
        .XFER_ACK_I(ack), .BUSY_O(busy),
        .TIMEOUT_O(tout), .CLR_ERR_I(clr)
    );

    cdc_hs_arbiter #(
        .NUM_REQ(4), .DATA_W(8), .ACK_TIMEOUT(255)
    ) dut6 (
        .CLK_I(clk), .RST_I(rst),
        .REQ_VALID_I(v6), .REQ_DATA_I(d6),
        .REQ_READY_O(r6), .XFER_REQ_O(xreq6),
        .XFER_DATA_O(xdata6), .XFER_ID_O(xid6),
        .XFER_ACK_I(ack6), .BUSY_O(busy6),
        .TIMEOUT_O(tout6), .CLR_ERR_I(clr6)
    );

    // Destination side: 2-flop sync of req, ack echoes it
    always @(posedge clk_d) begin
        if (rst) begin
            rs1  <= 1'b0;
            rs2  <= 1'b0;
            ackd <= 1'b0;
        end else begin
            rs1  <= xreq6;
            rs2  <= rs1;
            ackd <= rs2;
            if (rs2 && !ackd) rxq.push_back({xid6, xdata6});
        end
    end

    always @(posedge clk) begin
        if (rst) begin
            as1 <= 1'b0;
            as2 <= 1'b0;
        end else begin
            as1 <= ackd;
            as2 <= as1;
        end
    end
    assign ack6 = as2;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; valid = '0; ack = 1'b0; clr = 1'b0;
        repeat (4) tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; valid = 4'b1111; data = 32'hDEAD_BEEF;
        #1;
        n_chk++;
        if (ready !== 4'b0000) begin
            n_err++;
            $display("FAIL rst_ready: got %b want 0000", ready);
        end
        repeat (4) tick();
        n_chk++;
        if ({xreq, xdata, xid, busy, tout} !== 13'd0) begin
            n_err++;
            $display("FAIL rst_outs: req=%b data=%h id=%0d busy=%b to=%b want all 0",
                     xreq, xdata, xid, busy, tout);
        end
        valid = '0;
        rst = 1'b0;
    endtask

    task automatic test_single();
        valid = 4'b0100; data = 32'h00A5_0000;
        #1;
        n_chk++;
        if (ready !== 4'b0100) begin
            n_err++;
            $display("FAIL single_ready: got %b want 0100", ready);
        end
        tick();
        valid = '0;
        n_chk++;
        if ({xreq, busy, xid, xdata} !== {1'b1, 1'b1, 2'd2, 8'hA5}) begin
            n_err++;
            $display("FAIL single_xfer: req=%b busy=%b id=%0d data=%h want 1 1 2 a5",
                     xreq, busy, xid, xdata);
        end
        ack = 1'b1;
        tick();
        n_chk++;
        if ({xreq, busy} !== 2'b01) begin
            n_err++;
            $display("FAIL single_reqlo: req=%b busy=%b want 0 1", xreq, busy);
        end
        ack = 1'b0;
        tick();
        n_chk++;
        if ({xreq, busy} !== 2'b00) begin
            n_err++;
            $display("FAIL single_idle: req=%b busy=%b want 0 0", xreq, busy);
        end
    endtask

    task automatic test_round_robin();
        int ng = 0;
        int order[5] = '{0, 1, 2, 3, 0};
        logic pend = 1'b0;
        logic [1:0] eid = '0;
        do_reset();
        valid = 4'b1111; data = 32'h1312_1110;
        for (int cyc = 0; cyc < 60 && ng < 5; cyc++) begin
            #1;
            if (pend) begin
                pend = 1'b0;
                n_chk++;
                if ({xid, xdata} !== {eid, 8'h10 + {6'd0, eid}}) begin
                    n_err++;
                    $display("FAIL rr_capture: id=%0d data=%h want id=%0d",
                             xid, xdata, eid);
                end
            end
            if (ready !== 4'b0000) begin
                n_chk++;
                if (ready !== 4'(1 << order[ng])) begin
                    n_err++;
                    $display("FAIL rr_order: grant#%0d got %b want idx %0d",
                             ng, ready, order[ng]);
                end
                eid = 2'(order[ng]);
                pend = 1'b1;
                ng++;
            end
            tick();
            ack = xreq;
        end
        n_chk++;
        if (ng != 5) begin
            n_err++;
            $display("FAIL rr_timeout: got %0d grants want 5", ng);
        end
        valid = '0;
    endtask

    task automatic test_timeout();
        do_reset();
        valid = 4'b0001; data = 32'h0000_003C;
        #1;
        n_chk++;
        if (ready !== 4'b0001) begin
            n_err++;
            $display("FAIL to_grant: got %b want 0001", ready);
        end
        tick();
        valid = '0;
        repeat (7) tick();
        n_chk++;
        if ({tout, xreq} !== 2'b01) begin
            n_err++;
            $display("FAIL to_early: to=%b req=%b want 0 1", tout, xreq);
        end
        tick();
        n_chk++;
        if ({tout, xreq, busy} !== 3'b101) begin
            n_err++;
            $display("FAIL to_fire: to=%b req=%b busy=%b want 1 0 1", tout, xreq, busy);
        end
        tick();
        n_chk++;
        if ({tout, busy, xdata} !== {1'b1, 1'b0, 8'h3C}) begin
            n_err++;
            $display("FAIL to_recover: to=%b busy=%b data=%h want 1 0 3c",
                     tout, busy, xdata);
        end
        clr = 1'b1;
        tick();
        clr = 1'b0;
        n_chk++;
        if (tout !== 1'b0) begin
            n_err++;
            $display("FAIL to_clear: got %b want 0", tout);
        end
        valid = 4'b0010; data = 32'h0000_4B00; clr = 1'b1;
        tick();
        valid = '0;
        repeat (7) tick();
        n_chk++;
        if ({tout, xid, xdata} !== {1'b0, 2'd1, 8'h4B}) begin
            n_err++;
            $display("FAIL to_clr_hold: to=%b id=%0d data=%h want 0 1 4b",
                     tout, xid, xdata);
        end
        tick();
        n_chk++;
        if (tout !== 1'b1) begin
            n_err++;
            $display("FAIL to_set_wins: got %b want 1", tout);
        end
        tick();
        n_chk++;
        if (tout !== 1'b0) begin
            n_err++;
            $display("FAIL to_clr_after: got %b want 0", tout);
        end
        clr = 1'b0;
    endtask

    task automatic test_stale_ack();
        do_reset();
        ack = 1'b1; valid = 4'b0010; data = 32'h0000_7700;
        for (int i = 0; i < 3; i++) begin
            #1;
            n_chk++;
            if ({ready, busy} !== 5'b0) begin
                n_err++;
                $display("FAIL stale_ready: cyc %0d ready=%b busy=%b want 0", i, ready, busy);
            end
            tick();
        end
        ack = 1'b0;
        #1;
        n_chk++;
        if (ready !== 4'b0010) begin
            n_err++;
            $display("FAIL stale_grant: got %b want 0010", ready);
        end
        tick();
        valid = '0;
        n_chk++;
        if ({xreq, xid, xdata} !== {1'b1, 2'd1, 8'h77}) begin
            n_err++;
            $display("FAIL stale_xfer: req=%b id=%0d data=%h want 1 1 77", xreq, xid, xdata);
        end
        ack = 1'b1;
        tick();
        ack = 1'b0;
        tick();
    endtask

    task automatic test_reset_mid();
        do_reset();
        valid = 4'b0010; data = 32'h0000_5500;
        tick();
        valid = '0;
        n_chk++;
        if ({xreq, xid} !== 3'b1_01) begin
            n_err++;
            $display("FAIL mid_hi: req=%b id=%0d want 1 1", xreq, xid);
        end
        ack = 1'b1; rst = 1'b1;
        valid = 4'b1001; data = 32'h9900_0088;
        #1;
        n_chk++;
        if (ready !== 4'b0000) begin
            n_err++;
            $display("FAIL mid_rst_ready: got %b want 0000", ready);
        end
        tick();
        rst = 1'b0;
        n_chk++;
        if ({xreq, busy, xid, xdata} !== 12'd0) begin
            n_err++;
            $display("FAIL mid_rst_outs: req=%b busy=%b id=%0d data=%h want 0",
                     xreq, busy, xid, xdata);
        end
        for (int i = 0; i < 2; i++) begin
            #1;
            n_chk++;
            if (ready !== 4'b0000) begin
                n_err++;
                $display("FAIL mid_stale: cyc %0d got %b want 0000", i, ready);
            end
            tick();
        end
        ack = 1'b0;
        #1;
        n_chk++;
        if (ready !== 4'b0001) begin
            n_err++;
            $display("FAIL mid_ptr: got %b want 0001", ready);
        end
        tick();
        valid = '0;
        n_chk++;
        if ({xid, xdata} !== {2'd0, 8'h88}) begin
            n_err++;
            $display("FAIL mid_xfer: id=%0d data=%h want 0 88", xid, xdata);
        end
        ack = 1'b1;
        tick();
        ack = 1'b0;
        tick();
    endtask

    task automatic test_cdc();
        int issued = 0;
        int got = 0;
        int cyc = 0;
        int idx;
        logic [3:0] acc = '0;
        logic [9:0] rx, ex;
        while (got < 100 && cyc < 20000) begin
            for (int i = 0; i < 4; i++) begin
                if (acc[i]) v6[i] = 1'b0;
                if (!v6[i] && issued < 100 && $urandom_range(0, 3) == 0) begin
                    v6[i] = 1'b1;
                    d6[i*8 +: 8] = 8'($urandom);
                    issued++;
                end
            end
            #1;
            acc = r6;
            if (r6 !== 4'b0000) begin
                idx = 0;
                for (int i = 0; i < 4; i++) if (r6[i]) idx = i;
                n_chk++;
                if (((r6 & (r6 - 4'd1)) !== 4'd0) || ((r6 & ~v6) !== 4'd0)) begin
                    n_err++;
                    $display("FAIL cdc_ready: got %b valid %b", r6, v6);
                end
                expq.push_back({2'(idx), d6[idx*8 +: 8]});
            end
            while (rxq.size() > 0) begin
                rx = rxq.pop_front();
                got++;
                n_chk++;
                if (expq.size() == 0) begin
                    n_err++;
                    $display("FAIL cdc_extra: got %h want nothing", rx);
                end else begin
                    ex = expq.pop_front();
                    if (rx !== ex) begin
                        n_err++;
                        $display("FAIL cdc_order: xfer %0d got %h want %h", got, rx, ex);
                    end
                end
            end
            tick();
            cyc++;
        end
        v6 = '0;
        n_chk++;
        if (got != 100 || expq.size() != 0) begin
            n_err++;
            $display("FAIL cdc_count: got %0d left %0d want 100 0", got, expq.size());
        end
        n_chk++;
        if (tout6 !== 1'b0) begin
            n_err++;
            $display("FAIL cdc_timeout_flag: got %b want 0", tout6);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_timeout();
        test_stale_ack();
        test_reset_mid();
        test_cdc();
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
